// File: rtl/debug_frame_pkg.sv
// Shared frame layout and limits for the debug frame buffer.
// Consumers import debug_frame_pkg::* for the frame struct.
package debug_frame_pkg;

    localparam int FRAME_W    = 40;
    localparam int CMD_W      = 8;
    localparam int PAYLOAD_W  = 32;
    localparam int CMD_MSB    = 39;
    localparam int CMD_LSB    = 32;
    localparam int PARITY_BIT = 39;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef struct packed {
        logic [CMD_W-1:0]     cmd;
        logic [PAYLOAD_W-1:0] payload;
    } debug_frame_t;

endpackage

// File: rtl/debug_frame_fifo_if.sv
// Receiver/consumer bundle for debug_frame_fifo.
// parity_err exists only when DEBUG_FRAME_PARITY_EN is defined.
interface debug_frame_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [39:0]   in_data;
    logic          in_valid;
    logic [7:0]    out_cmd;
    logic [31:0]   out_payload;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic          overflow_clear;
    logic [7:0]    drop_count;
`ifdef DEBUG_FRAME_PARITY_EN
    logic          parity_err;
`endif

    modport master (
        output in_data, in_valid, out_ready, overflow_clear,
        input  out_cmd, out_payload, out_valid, level,
`ifdef DEBUG_FRAME_PARITY_EN
        input  parity_err,
`endif
        input  overflow, drop_count
    );

    modport slave (
        input  in_data, in_valid, out_ready, overflow_clear,
        output out_cmd, out_payload, out_valid, level,
`ifdef DEBUG_FRAME_PARITY_EN
        output parity_err,
`endif
        output overflow, drop_count
    );

endinterface

// File: rtl/debug_frame_parity.sv
// Odd-parity check over a full 40-bit debug frame.
// ok is high when the frame holds an odd number of ones.
module debug_frame_parity
    import debug_frame_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic               ok
);

    assign ok = ^frame;

endmodule

// File: rtl/debug_frame_fifo.sv
// Frame FIFO between the serial debug receiver and command logic.
// Optional parity rejection under DEBUG_FRAME_PARITY_EN.
module debug_frame_fifo
    import debug_frame_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic              debug_clk,
    input logic              reset,
    debug_frame_fifo_if.slave f
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    debug_frame_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next, wr_next;
    logic [LW-1:0] level, level_next;
    debug_frame_t  head, head_next, in_frame;
    logic          out_valid, overflow;
    logic [7:0]    drop_count;
    logic          frame_ok, full, pop, push, drop_full, drop;

`ifdef DEBUG_FRAME_PARITY_EN
    logic parity_err;

    debug_frame_parity u_parity (
        .frame (f.in_data),
        .ok    (frame_ok)
    );

    assign f.parity_err = parity_err;
`else
    assign frame_ok = 1'b1;
`endif

    assign in_frame  = debug_frame_t'(f.in_data);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid && f.out_ready;
    assign push      = f.in_valid && frame_ok && (!full || pop);
    assign drop_full = f.in_valid && frame_ok && full && !pop;
    assign drop      = drop_full || (f.in_valid && !frame_ok);
    assign rd_next   = pop  ? rd_ptr + 1'b1 : rd_ptr;
    assign wr_next   = push ? wr_ptr + 1'b1 : wr_ptr;

    // A frame written into the slot that becomes head bypasses storage.
    assign head_next = (push && wr_ptr == rd_next) ? in_frame
                                                   : mem[rd_next];

    always_comb begin
        level_next = level;
        unique case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
`ifdef DEBUG_FRAME_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_frame;
            end
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            level     <= level_next;
            head      <= head_next;
            out_valid <= (level_next != '0);
            if (drop_full) begin
                overflow <= 1'b1;
            end else if (f.overflow_clear) begin
                overflow <= 1'b0;
            end
            if (drop && drop_count != DROP_MAX) begin
                drop_count <= drop_count + 1'b1;
            end
`ifdef DEBUG_FRAME_PARITY_EN
            parity_err <= f.in_valid && !frame_ok;
`endif
        end
    end

    assign f.out_cmd     = head.cmd;
    assign f.out_payload = head.payload;
    assign f.out_valid   = out_valid;
    assign f.level       = level;
    assign f.overflow    = overflow;
    assign f.drop_count  = drop_count;

endmodule

// File: tb/tb_debug_frame_fifo.sv
// Scoreboard bench for debug_frame_fifo (DEPTH=4).
// Also exercises parity rejection when DEBUG_FRAME_PARITY_EN is defined.
module tb_debug_frame_fifo;

    localparam int DEPTH = 4;

    logic debug_clk = 1'b0;
    logic reset     = 1'b1;

    always #5 debug_clk = ~debug_clk;

    debug_frame_fifo_if #(.DEPTH(DEPTH)) f ();

    debug_frame_fifo #(.DEPTH(DEPTH)) dut (
        .debug_clk (debug_clk),
        .reset     (reset),
        .f         (f)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0] q[$];
    logic        m_ovf;
    int          m_drops;
    logic        m_perr;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] fr(input logic [39:0] x);
        logic [39:0] y;
        y = x;
`ifdef DEBUG_FRAME_PARITY_EN
        y[39] = ~(^x[38:0]);
`endif
        return y;
    endfunction

    function automatic logic bad_par(input logic [39:0] x);
`ifdef DEBUG_FRAME_PARITY_EN
        return ~(^x);
`else
        return 1'b0 & x[0];
`endif
    endfunction

    task automatic check_outs();
        check("out_valid", 64'(f.out_valid), 64'(q.size() != 0));
        check("level", 64'(f.level), 64'(q.size()));
        check("overflow", 64'(f.overflow), 64'(m_ovf));
        check("drop_count", 64'(f.drop_count), 64'(m_drops));
        if (q.size() != 0) begin
            check("head", {24'h0, f.out_cmd, f.out_payload},
                  {24'h0, q[0]});
        end
`ifdef DEBUG_FRAME_PARITY_EN
        check("parity_err", 64'(f.parity_err), 64'(m_perr));
`endif
    endtask

    task automatic step(input logic v, input logic [39:0] d,
                        input logic rdy, input logic clr);
        logic pop, full, bad;
        f.in_valid       = v;
        f.in_data        = d;
        f.out_ready      = rdy;
        f.overflow_clear = clr;
        @(posedge debug_clk);
        pop  = (q.size() != 0) && rdy;
        full = (q.size() == DEPTH);
        bad  = v && bad_par(d);
        m_perr = bad;
        if (pop) void'(q.pop_front());
        if (v && !bad) begin
            if (!full || pop) q.push_back(d);
            else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end else begin
            if (bad && m_drops < 255) m_drops++;
            if (clr) m_ovf = 1'b0;
        end
        if (v && !bad && full && !pop) m_ovf = 1'b1;
        else if (clr && !(v && !bad && full && !pop)) m_ovf = 1'b0;
        @(negedge debug_clk);
        f.in_valid       = 1'b0;
        f.out_ready      = 1'b0;
        f.overflow_clear = 1'b0;
        check_outs();
    endtask

    function automatic logic [39:0] rnd();
        return fr({8'($urandom), 32'($urandom)});
    endfunction

    initial begin
        f.in_valid       = 1'b0;
        f.in_data        = '0;
        f.out_ready      = 1'b0;
        f.overflow_clear = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
        m_perr  = 1'b0;

        repeat (2) @(negedge debug_clk);
        check("rst_cmd", 64'(f.out_cmd), 64'h0);
        check("rst_payload", 64'(f.out_payload), 64'h0);
        check_outs();
        reset = 1'b0;
        @(negedge debug_clk);

        // single frame
        step(1'b1, fr(40'hA5_12345678), 1'b0, 1'b0);
        check("single_cmd", 64'(f.out_cmd), 64'(fr(40'hA5_12345678) >> 32));
        check("single_pl", 64'(f.out_payload), 64'h12345678);
        step(1'b0, '0, 1'b1, 1'b0);
        check("single_empty", 64'(f.out_valid), 64'h0);

        // fill and overflow, then drain in order
        for (int i = 0; i < 5; i++) step(1'b1, rnd(), 1'b0, 1'b0);
        check("fill_ovf", 64'(f.overflow), 64'h1);
        check("fill_drop", 64'(f.drop_count), 64'h1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // push+pop while full, clear racing a drop, then clear
        for (int i = 0; i < 4; i++) step(1'b1, rnd(), 1'b0, 1'b0);
        step(1'b1, rnd(), 1'b1, 1'b0);
        check("full_pp_lvl", 64'(f.level), 64'd4);
        step(1'b1, rnd(), 1'b0, 1'b1);
        check("clr_vs_drop", 64'(f.overflow), 64'h1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("clr", 64'(f.overflow), 64'h0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // saturation
        for (int i = 0; i < 4; i++) step(1'b1, rnd(), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, rnd(), 1'b0, 1'b0);
        check("sat", 64'(f.drop_count), 64'd255);

        // random traffic
        for (int i = 0; i < 200; i++)
            step(1'($urandom), rnd(), 1'($urandom), 1'($urandom_range(0, 7) == 0));

        // reset mid-burst at level 3
        while (q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b0, 1'b0);
        check("pre_rst_lvl", 64'(f.level), 64'd3);
        #2 reset = 1'b1;
        #1;
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        m_perr  = 1'b0;
        check("arst_cmd", 64'(f.out_cmd), 64'h0);
        check("arst_payload", 64'(f.out_payload), 64'h0);
        check_outs();
        @(negedge debug_clk);
        reset = 1'b0;
        step(1'b1, fr(40'h3C_DEADBEEF), 1'b0, 1'b0);
        check("post_rst_head", 64'(f.out_payload), 64'hDEADBEEF);

`ifdef DEBUG_FRAME_PARITY_EN
        step(1'b1, fr(40'h11_00000001) ^ 40'h1, 1'b0, 1'b0);
        check("perr_pulse", 64'(f.parity_err), 64'h1);
        check("perr_lvl", 64'(f.level), 64'd1);
        check("perr_ovf", 64'(f.overflow), 64'h0);
        step(1'b1, fr(40'h11_00000001), 1'b0, 1'b0);
        check("par_ok_lvl", 64'(f.level), 64'd2);
`endif
        while (q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_frame_fifo.md
# debug_frame_fifo

Buffers complete 40-bit debug frames from the serial debug receiver and hands them to the debug command logic as command byte plus 32-bit payload. Sits directly downstream of the receiver, in the `debug_clk` domain. Absorbs bursts of back-to-back frames when the consumer stalls, and reports frames it had to drop.

## Interface
- `DEPTH`, default 4: number of frame slots; power of two, 2 to 16.
- `debug_clk`  in  1  debug serial clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  40  received frame, MSB first; `[39:32]` is the command, `[31:0]` is the payload.
- `in_valid`  in  1  single-cycle pulse; `in_data` is stable while it is high.
- `out_cmd`  out  8  command byte of the head frame.
- `out_payload`  out  32  payload of the head frame.
- `out_valid`  out  1  head frame present.
- `out_ready`  in  1  consumer accepts the head frame.
- `level`  out  $clog2(DEPTH)+1  frames currently stored.
- `overflow`  out  1  sticky: at least one frame was dropped because the FIFO was full.
- `overflow_clear`  in  1  clears `overflow`.
- `drop_count`  out  8  frames dropped since reset; saturates at 255.

## Operation
- Circular buffer with `DEPTH` slots, a write pointer, a read pointer and an occupancy counter. Pointers wrap modulo `DEPTH`.
- **Push:** `in_valid` is high at an edge and the frame is accepted. The frame is written at the write pointer, the write pointer advances, and `level` increments.
- **Pop:** `out_valid && out_ready` at an edge. The read pointer advances and `level` decrements.
- `out_cmd`, `out_payload` and `out_valid` are registered.
  - They always reflect the slot at the read pointer after the edge.
  - `out_valid = (level != 0)`.
- **Push and pop in the same edge:** both happen and `level` is unchanged. This includes the full case: the pop frees a slot and the push is accepted.
- **Push when full without a pop:** the frame is discarded. Storage and pointers are unchanged, `overflow` sets, and `drop_count` increments (it holds at 255).
- **Pop when empty:** ignored. `out_ready` is don't-care while `out_valid` is low.
- **`overflow_clear`:** clears `overflow` on the next edge. If a new drop occurs on that same edge, the set wins and `overflow` stays 1.
- `drop_count` is cleared only by reset.
- **Reset (asynchronous, any time, including mid-burst):**
  - All outputs are 0.
  - Pointers are 0.
  - Storage is cleared to 0.
  - Any frame presented on the reset edge is lost.

## Timing
- **Latency from a push into an empty FIFO:** 1 cycle.
  - `in_valid` is sampled at edge N.
  - `out_valid`, `out_cmd` and `out_payload` are valid after edge N.
- **Pop:** after the popping edge, the next frame (or `out_valid = 0`) appears with zero bubble.
- `level`, `overflow` and `drop_count` update on the same edge as the event that changes them.
- **Input rate:** `in_valid` pulses are at least 41 cycles apart in normal operation. The block nevertheless accepts a push on every cycle.
- The receiver changes its valid on the falling edge, so `in_valid` is stable at the rising edge. No extra synchroniser is used.

## Configuration
- Macro: `DEBUG_FRAME_PARITY_EN`.
- **Defined:**
  - `in_data[39]` is an odd-parity bit over `in_data[38:0]`.
  - A frame with bad parity is never stored. It increments `drop_count` but does not set `overflow`.
  - The port `parity_err`  out  1 pulses high for one cycle after the edge that rejected the frame. Its reset value is 0.
  - `out_cmd[7]` still carries the parity bit as received.
- **Undefined:** no parity check and no `parity_err` port. All frames are subject only to the full check.

## Structure
- Package `debug_frame_pkg` holds:
  - `FRAME_W=40`, `CMD_W=8`, `PAYLOAD_W=32`;
  - field positions `CMD_MSB=39`, `CMD_LSB=32`, `PARITY_BIT=39`;
  - `DROP_MAX=8'hFF`;
  - a packed typedef `debug_frame_t` with `cmd` and `payload` fields.
- One sub-module, `debug_frame_parity`: combinational odd-parity check over 40 bits, instantiated only under `DEBUG_FRAME_PARITY_EN`.
- The storage array and pointers are written inline in `debug_frame_fifo`.

## Test plan
- **Single frame:** push `40'hA5_12345678` with `out_ready=0` → after 1 cycle `out_valid=1`, `out_cmd=8'hA5`, `out_payload=32'h12345678`, `level=1`. Then raise `out_ready` for one edge → `out_valid=0`, `level=0`.
- **Fill and overflow (`DEPTH=4`):** push 5 frames with `out_ready=0` → `level=4`, `overflow=1`, `drop_count=1`, head is still the first frame. Drain → the four frames come out in order.
- **Simultaneous push/pop when full:** → `level` stays 4, no drop, and the new frame appears fourth in the drain order. Assert `overflow_clear` on the same edge as another drop → `overflow` remains 1.
- **Saturation:** 300 pushes while full → `drop_count=255`.
- **Reset mid-burst:** assert `reset` asynchronously between edges with `level=3` → all outputs are 0 immediately. The first push after release appears as the head.
- **Parity (`DEBUG_FRAME_PARITY_EN`):**
  - Push a frame with even parity → `parity_err` pulses, `drop_count+1`, `overflow=0`, `level` unchanged.
  - Push a correct odd-parity frame → stored.
